// File: rtl/sensor_conv_sched.sv
`default_nettype none
// ============================================================================
// sensor_conv_sched : shares one synchronized edge counter between two sensor
// oscillators. Optional auto-trigger is enabled by SEQ_AUTO_EN.   Rev 1.0
// ============================================================================
module sensor_conv_sched #(
   parameter int CNT_W         = 16,
   parameter int WIN_CYCLES    = 1024,
   parameter int RST_CYCLES    = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int AUTO_PERIOD   = 65536
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [1:0]       req_i,
   input  logic [1:0]       osc_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       sens_rst_o,
   output logic             busy_o,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [CNT_W-1:0] res_data_o,
   output logic             res_chan_o,
   output logic             res_ovf_o
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_RESET  = 3'd1;
   localparam logic [2:0] c_SETTLE = 3'd2;
   localparam logic [2:0] c_COUNT  = 3'd3;
   localparam logic [2:0] c_HOLD   = 3'd4;

   localparam int c_TMR_MAX =
      (WIN_CYCLES > RST_CYCLES)
         ? ((WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES)
         : ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
   localparam int c_TMR_W = $clog2(c_TMR_MAX + 1);

   logic [1:0]         sync1_q, sync2_q, sync3_q;
   logic [1:0]         w_edge;
   logic               w_chan_edge;

   logic [2:0]         state_q, state_d;
   logic [c_TMR_W-1:0] tmr_q, tmr_d;
   logic               chan_q, chan_d;
   logic               pref_q, pref_d;
   logic [1:0]         gnt_q, gnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic [1:0]         w_req;
   logic               w_pick;
   logic               w_hs;

   // Two flops resolve metastability; the third holds the previous level.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         sync3_q <= 2'b00;
      end else begin
         sync1_q <= osc_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign w_edge      = sync2_q & ~sync3_q;
   assign w_chan_edge = chan_q ? w_edge[1] : w_edge[0];
   assign w_hs        = (state_q == c_HOLD) && res_ready_i;

`ifdef SEQ_AUTO_EN
   localparam int c_AUTO_W = $clog2(AUTO_PERIOD + 1);

   logic [c_AUTO_W-1:0] auto_cnt_q;
   logic [1:0]          auto_flag_q;
   logic                w_expire;
   logic [1:0]          w_auto_clr;

   assign w_expire   = (auto_cnt_q == c_AUTO_W'(AUTO_PERIOD - 1));
   assign w_auto_clr = w_hs ? (chan_q ? 2'b10 : 2'b01) : 2'b00;

   // Expiry is applied after the clear so a coincident expiry re-arms the flag.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         auto_cnt_q  <= '0;
         auto_flag_q <= 2'b00;
      end else begin
         auto_cnt_q  <= w_expire ? '0 : auto_cnt_q + c_AUTO_W'(1);
         auto_flag_q <= (auto_flag_q & ~w_auto_clr) | {2{w_expire}};
      end
   end

   assign w_req = req_i | auto_flag_q;
`else
   assign w_req = req_i;
`endif

   assign w_pick = (w_req == 2'b11) ? pref_q : w_req[1];

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      chan_d  = chan_q;
      pref_d  = pref_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         c_IDLE: begin
            if (|w_req) begin
               chan_d  = w_pick;
               gnt_d   = w_pick ? 2'b10 : 2'b01;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               tmr_d   = c_TMR_W'(RST_CYCLES - 1);
               state_d = c_RESET;
            end
         end
         c_RESET: begin
            if (tmr_q == '0) begin
               tmr_d   = c_TMR_W'(SETTLE_CYCLES - 1);
               state_d = c_SETTLE;
            end else begin
               tmr_d = tmr_q - c_TMR_W'(1);
            end
         end
         c_SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d   = c_TMR_W'(WIN_CYCLES - 1);
               state_d = c_COUNT;
            end else begin
               tmr_d = tmr_q - c_TMR_W'(1);
            end
         end
         c_COUNT: begin
            if (w_chan_edge) begin
               if (&cnt_q) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (tmr_q == '0) begin
               state_d = c_HOLD;
            end else begin
               tmr_d = tmr_q - c_TMR_W'(1);
            end
         end
         c_HOLD: begin
            if (w_hs) begin
               gnt_d   = 2'b00;
               pref_d  = ~chan_q;
               state_d = c_IDLE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= c_IDLE;
         tmr_q   <= '0;
         chan_q  <= 1'b0;
         pref_q  <= 1'b0;
         gnt_q   <= 2'b00;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         chan_q  <= chan_d;
         pref_q  <= pref_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign sens_rst_o  = (state_q == c_RESET) ? gnt_q : 2'b00;
   assign busy_o      = (state_q != c_IDLE);
   assign res_valid_o = (state_q == c_HOLD);
   assign res_data_o  = cnt_q;
   assign res_chan_o  = chan_q;
   assign res_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conv_sched.sv
`default_nettype none
// Testbench for sensor_conv_sched: randomized oscillator phases/periods checked
// against an arithmetic edge-count and arbitration model.
module tb_sensor_conv_sched;
   localparam int CNT_W = 8;
   localparam int WIN   = 1024;
   localparam int RSTC  = 8;
   localparam int SETC  = 16;
   localparam int AUTO  = 4096;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_i;
   logic [1:0]       req_i;
   logic [1:0]       osc_i;
   logic [1:0]       gnt_o;
   logic [1:0]       sens_rst_o;
   logic             busy_o;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [CNT_W-1:0] res_data_o;
   logic             res_chan_o;
   logic             res_ovf_o;

   int cyc = 0;
   int per[2];
   int ph[2];
   int pref;
   int n_chk = 0;
   int n_pass = 0;

   sensor_conv_sched #(
      .CNT_W(CNT_W), .WIN_CYCLES(WIN), .RST_CYCLES(RSTC),
      .SETTLE_CYCLES(SETC), .AUTO_PERIOD(AUTO)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i), .osc_i(osc_i),
      .gnt_o(gnt_o), .sens_rst_o(sens_rst_o), .busy_o(busy_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_data_o(res_data_o), .res_chan_o(res_chan_o), .res_ovf_o(res_ovf_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cyc <= cyc + 1;

   // Square wave per channel; a rising edge is set after clock edge j when (j+ph)%per==0.
   initial begin
      osc_i = 2'b00;
      forever begin
         @(negedge wb_clk_i);
         for (int c = 0; c < 2; c++)
            osc_i[c] = (per[c] > 0) && (((cyc + ph[c]) % per[c]) < per[c] / 2);
      end
   end

   // An osc rise set after edge j is counted at edge j+3 if that edge lies in the window.
   function automatic int exp_count(input int e0, input int c);
      int n = 0;
      for (int j = e0 + RSTC + SETC - 2; j <= e0 + RSTC + SETC + WIN - 3; j++)
         if (per[c] > 0 && ((j + ph[c]) % per[c]) == 0) n++;
      return n;
   endfunction

   function automatic int sat(input int n);
      return (n > MAXC) ? MAXC : n;
   endfunction

   task automatic apply_reset();
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1; req_i = 2'b00; res_ready_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      pref = 0;
   endtask

   // Drives one conversion to its handshake and returns what was observed.
   task automatic do_conv(input int budget, input int rdy_delay,
                          output bit to, output int e0, output int vlat, output int rlen,
                          output int hs, output logic [1:0] g, output logic [1:0] sr,
                          output logic [CNT_W-1:0] d, output logic c, output logic o,
                          output bit held_ok);
      int k;
      to = 0; e0 = 0; vlat = 0; rlen = 0; hs = 0; g = 0; sr = 0;
      d = 0; c = 0; o = 0; held_ok = 1;
      k = 0;
      while (gnt_o == 2'b00 && k < budget) begin
         @(negedge wb_clk_i);
         k++;
      end
      if (gnt_o == 2'b00) begin to = 1; return; end
      e0 = cyc; g = gnt_o; sr = sens_rst_o;
      if (rdy_delay < 0) res_ready_i = 1'b1;
      k = 0;
      while (!res_valid_o && k < 3000) begin
         if (|sens_rst_o) rlen++;
         @(negedge wb_clk_i);
         k++;
      end
      if (!res_valid_o) begin to = 1; res_ready_i = 1'b0; return; end
      vlat = cyc - e0; d = res_data_o; c = res_chan_o; o = res_ovf_o;
      if (rdy_delay >= 0) begin
         repeat (rdy_delay) begin
            @(negedge wb_clk_i);
            if (res_data_o !== d || res_chan_o !== c || res_ovf_o !== o ||
                res_valid_o !== 1'b1 || busy_o !== 1'b1) held_ok = 0;
         end
         res_ready_i = 1'b1;
      end
      @(negedge wb_clk_i);
      res_ready_i = 1'b0;
      hs = cyc;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge wb_clk_i);
      n_chk++;
      if ({gnt_o, sens_rst_o, busy_o, res_valid_o, res_data_o, res_chan_o, res_ovf_o} !== '0)
         $display("FAIL reset_outputs: got gnt=%b srst=%b busy=%b v=%b d=%0d ch=%b ovf=%b want all 0",
                  gnt_o, sens_rst_o, busy_o, res_valid_o, res_data_o, res_chan_o, res_ovf_o);
      else n_pass++;
   endtask

   task automatic test_single();
      bit to, hk; int e0, vl, rl, hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      apply_reset();
      per[0] = 8; ph[0] = $urandom_range(0, 99); per[1] = 0; ph[1] = 0;
      @(negedge wb_clk_i);
      req_i = 2'b01;
      do_conv(50, 2, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
      req_i = 2'b00;
      n_chk++; if (to) $display("FAIL single_timeout: got timeout want completion"); else n_pass++;
      n_chk++; if (g !== 2'b01) $display("FAIL single_gnt: got %b want 01", g); else n_pass++;
      n_chk++; if (sr !== 2'b01) $display("FAIL single_srst: got %b want 01", sr); else n_pass++;
      n_chk++; if (rl !== RSTC) $display("FAIL single_rst_len: got %0d want %0d", rl, RSTC); else n_pass++;
      n_chk++; if (vl !== 1048) $display("FAIL single_latency: got %0d want 1048", vl); else n_pass++;
      n_chk++; if (d !== CNT_W'(128)) $display("FAIL single_data: got %0d want 128", d); else n_pass++;
      n_chk++; if (d !== CNT_W'(sat(exp_count(e0, 0))))
         $display("FAIL single_model: got %0d want %0d", d, sat(exp_count(e0, 0))); else n_pass++;
      n_chk++; if ({c, o} !== 2'b00) $display("FAIL single_chan_ovf: got %b%b want 00", c, o); else n_pass++;
      pref = 1;
   endtask

   task automatic test_contention();
      bit to, hk; int e0, vl, rl, hs, prev_hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      int want;
      apply_reset();
      per[0] = 6;  ph[0] = $urandom_range(0, 99);
      per[1] = 10; ph[1] = $urandom_range(0, 99);
      @(negedge wb_clk_i);
      req_i = 2'b11;
      prev_hs = -1;
      for (int i = 0; i < 3; i++) begin
         want = (i == 1) ? 1 : 0;
         do_conv(50, i, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
         if (i == 2) req_i = 2'b00;
         n_chk++; if (to || c !== want[0])
            $display("FAIL contention_chan%0d: got %b (to=%0d) want %0d", i, c, to, want); else n_pass++;
         n_chk++; if (g !== (want == 1 ? 2'b10 : 2'b01))
            $display("FAIL contention_gnt%0d: got %b want onehot ch%0d", i, g, want); else n_pass++;
         n_chk++; if (d !== CNT_W'(sat(exp_count(e0, want))))
            $display("FAIL contention_data%0d: got %0d want %0d", i, d, sat(exp_count(e0, want))); else n_pass++;
         if (prev_hs >= 0) begin
            n_chk++; if (e0 !== prev_hs + 1)
               $display("FAIL contention_regrant%0d: got edge %0d want %0d", i, e0, prev_hs + 1); else n_pass++;
         end
         prev_hs = hs;
      end
      pref = 1;
   endtask

   task automatic test_saturation();
      bit to, hk; int e0, vl, rl, hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      per[0] = 0; per[1] = 4; ph[1] = $urandom_range(0, 99);
      @(negedge wb_clk_i);
      req_i = 2'b10;
      do_conv(50, 1, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
      req_i = 2'b00;
      n_chk++; if (to || c !== 1'b1) $display("FAIL sat_chan: got %b (to=%0d) want 1", c, to); else n_pass++;
      n_chk++; if (d !== CNT_W'(255)) $display("FAIL sat_data: got %0d want 255", d); else n_pass++;
      n_chk++; if (o !== 1'b1) $display("FAIL sat_ovf: got %b want 1", o); else n_pass++;
      n_chk++; if (exp_count(e0, 1) <= MAXC || d !== CNT_W'(sat(exp_count(e0, 1))))
         $display("FAIL sat_model: got %0d want %0d", d, sat(exp_count(e0, 1))); else n_pass++;
      pref = 0;
   endtask

   task automatic test_backpressure();
      bit to, hk; int e0, vl, rl, hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      per[0] = 5; ph[0] = $urandom_range(0, 99); per[1] = 7;
      @(negedge wb_clk_i);
      req_i = 2'b01;
      do_conv(50, 50, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
      req_i = 2'b00;
      n_chk++; if (to || !hk) $display("FAIL bp_hold: got held_ok=%0d to=%0d want 1,0", hk, to); else n_pass++;
      n_chk++; if ({gnt_o, busy_o, res_valid_o} !== 4'b0000)
         $display("FAIL bp_after_hs: got gnt=%b busy=%b v=%b want 00 0 0", gnt_o, busy_o, res_valid_o); else n_pass++;
      n_chk++; if (d !== CNT_W'(sat(exp_count(e0, 0))) || c !== 1'b0)
         $display("FAIL bp_data: got %0d ch%b want %0d ch0", d, c, sat(exp_count(e0, 0))); else n_pass++;
      pref = 1;
   endtask

   task automatic test_reset_mid();
      bit to, hk; int e0, vl, rl, hs, k; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      per[0] = 8; ph[0] = $urandom_range(0, 99);
      @(negedge wb_clk_i);
      req_i = 2'b01;
      k = 0;
      while (gnt_o == 2'b00 && k < 50) begin @(negedge wb_clk_i); k++; end
      e0 = cyc;
      while (cyc < e0 + RSTC + SETC + 500 && k < 2000) begin @(negedge wb_clk_i); k++; end
      req_i = 2'b00;
      #2 wb_rst_i = 1'b1;
      #1;
      n_chk++;
      if ({gnt_o, sens_rst_o, busy_o, res_valid_o, res_data_o, res_chan_o, res_ovf_o} !== '0)
         $display("FAIL rstmid_outputs: got gnt=%b busy=%b d=%0d want all 0", gnt_o, busy_o, res_data_o);
      else n_pass++;
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      pref = 0;
      per[0] = 7; ph[0] = $urandom_range(0, 99);
      @(negedge wb_clk_i);
      req_i = 2'b01;
      do_conv(50, 0, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
      req_i = 2'b00;
      n_chk++; if (to || vl !== 1048 || rl !== RSTC)
         $display("FAIL rstmid_restart: got lat=%0d rlen=%0d want 1048,%0d", vl, rl, RSTC); else n_pass++;
      n_chk++; if (d !== CNT_W'(sat(exp_count(e0, 0))))
         $display("FAIL rstmid_data: got %0d want %0d", d, sat(exp_count(e0, 0))); else n_pass++;
      pref = 1;
   endtask

   task automatic test_random();
      bit to, hk; int e0, vl, rl, hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      int r, dly, want, n;
      for (int i = 0; i < 4; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            per[ch] = $urandom_range(4, 12);
            ph[ch]  = $urandom_range(0, 99);
         end
         r   = $urandom_range(1, 3);
         dly = $urandom_range(0, 6) - 1;
         want = (r == 3) ? pref : ((r == 2) ? 1 : 0);
         repeat (4) @(negedge wb_clk_i);
         req_i = r[1:0];
         do_conv(50, dly, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
         req_i = 2'b00;
         n = exp_count(e0, want);
         n_chk++; if (to || c !== want[0] || g !== (want == 1 ? 2'b10 : 2'b01))
            $display("FAIL rand%0d_arb: got ch%b gnt=%b want ch%0d", i, c, g, want); else n_pass++;
         n_chk++; if (d !== CNT_W'(sat(n)) || o !== (n > MAXC))
            $display("FAIL rand%0d_data: got %0d ovf=%b want %0d ovf=%0d", i, d, o, sat(n), n > MAXC);
         else n_pass++;
         n_chk++; if (vl !== RSTC + SETC + WIN || rl !== RSTC)
            $display("FAIL rand%0d_timing: got lat=%0d rlen=%0d", i, vl, rl); else n_pass++;
         pref = 1 - want;
      end
   endtask

`ifdef SEQ_AUTO_EN
   task automatic test_auto();
      bit to, hk; int e0, vl, rl, hs; logic [1:0] g, sr; logic [CNT_W-1:0] d; logic c, o;
      int want;
      apply_reset();
      per[0] = 6; ph[0] = $urandom_range(0, 99);
      per[1] = 9; ph[1] = $urandom_range(0, 99);
      for (int i = 0; i < 4; i++) begin
         want = i % 2;
         do_conv(9000, 1, to, e0, vl, rl, hs, g, sr, d, c, o, hk);
         n_chk++; if (to || c !== want[0])
            $display("FAIL auto%0d_chan: got %b (to=%0d) want %0d", i, c, to, want); else n_pass++;
         n_chk++; if (d !== CNT_W'(sat(exp_count(e0, want))))
            $display("FAIL auto%0d_data: got %0d want %0d", i, d, sat(exp_count(e0, want))); else n_pass++;
      end
   endtask
`endif

   initial begin
      wb_rst_i = 1'b1; req_i = 2'b00; res_ready_i = 1'b0;
      per[0] = 0; per[1] = 0; ph[0] = 0; ph[1] = 0; pref = 0;
      test_reset();
`ifdef SEQ_AUTO_EN
      test_auto();
`else
      test_single();
      test_contention();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_random();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sensor_conv_sched.md
# sensor_conv_sched

Conversion scheduler that shares one synchronized edge counter between two free-running sensor oscillators: channel 0 is the temperature VCO output and channel 1 is the LVDT-side oscillator. Per conversion it pulses that sensor's reset, waits a settle interval, and counts rising edges over a fixed gate window. It returns the count to the requester through a valid/ready handshake. It sits in the user project area between the analog macros and the Wishbone/LA register layer, and replaces ad-hoc gating of the counter clock.

## Interface
Parameters:
- CNT_W, 16, result counter width (4..24)
- WIN_CYCLES, 1024, gate window length in clock cycles (>=1)
- RST_CYCLES, 8, sensor reset pulse length in cycles (>=1)
- SETTLE_CYCLES, 16, post-reset settle length in cycles (>=1)
- AUTO_PERIOD, 65536, auto-trigger interval in cycles (used only with SEQ_AUTO_EN)

Ports:
- wb_clk_i  in  1  system clock; sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_i  in  2  per-channel conversion request, level
- osc_i  in  2  asynchronous oscillator inputs (bit 0 temp VCO, bit 1 LVDT)
- gnt_o  out  2  one-hot grant, channel currently owning the counter
- sens_rst_o  out  2  per-channel sensor reset, active-high
- busy_o  out  1  FSM not in IDLE
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_data_o  out  CNT_W  edge count
- res_chan_o  out  1  channel of result
- res_ovf_o  out  1  count saturated

## Operation
- Each osc_i bit passes through a 2-flop synchronizer plus a rising-edge detector in wb_clk_i. The detector produces a 1-cycle pulse per edge. The synchronizers are always running.
- FSM states: IDLE, RESET, SETTLE, COUNT, HOLD.
- IDLE: an effective request exists when req_i is set, or an auto flag is set. Arbitration picks a channel:
  - one requester wins;
  - if both request, the channel not served last wins (round-robin pointer);
  - the pointer resets to favour channel 0.
  - On a win: latch the channel, set gnt_o, go to RESET.
- RESET: sens_rst_o[ch]=1 for RST_CYCLES cycles, then go to SETTLE. The counter clears to 0 on entry.
- SETTLE: SETTLE_CYCLES cycles with no counting, then go to COUNT.
- COUNT: for WIN_CYCLES cycles, each edge pulse of the latched channel increments the counter.
  - At all-ones the counter holds (saturates) and sets the ovf flag.
  - Pulses of the other channel are ignored.
  - After COUNT, go to HOLD.
- HOLD: res_valid_o=1, with res_data_o, res_chan_o and res_ovf_o stable.
  - On res_valid_o&&res_ready_i: clear valid, clear gnt_o, update the pointer, go to IDLE.
- A conversion, once granted, always completes. Deasserting req_i mid-conversion has no effect.
- If req_i is still high on return to IDLE, a new conversion starts. Requesters drop req_i after their handshake.

## Timing
- Reset state: all outputs 0, FSM in IDLE, counter 0, pointer favours channel 0. Reset is asynchronous and may assert in any state; it aborts the conversion.
- Request sampled at edge E0 (FSM in IDLE) → gnt_o, busy_o and sens_rst_o[ch] high after E0.
- sens_rst_o falls after edge E0+RST_CYCLES.
- COUNT occupies edges E0+RST_CYCLES+SETTLE_CYCLES+1 through E0+RST_CYCLES+SETTLE_CYCLES+WIN_CYCLES.
- res_valid_o rises after E0+RST_CYCLES+SETTLE_CYCLES+WIN_CYCLES. With defaults this is 1048 cycles.
- Counted edges are the detector pulses present during COUNT cycles. The synchronizer latency is 3 cycles. Osc edges must be at least 2 clock periods apart to be counted exactly.
- Handshake cycle returns to IDLE. The earliest next grant is one cycle later (IDLE always lasts at least 1 cycle).
- res_ready_i high before valid has no effect. The result holds indefinitely without ready.

## Configuration
- SEQ_AUTO_EN defined:
  - A free-running interval counter expires every AUTO_PERIOD cycles.
  - On expiry it sets auto flags for both channels.
  - Each flag is ORed into that channel's request and clears on that channel's result handshake.
  - An expiry coinciding with the clear leaves the flag set.
- SEQ_AUTO_EN undefined: no interval counter or flags. Conversions come only from req_i.

## Test plan
- Single conversion: osc_i[0] period 8 clocks, req_i=01 → sens_rst_o[0] high 8 cycles; res_valid_o after 1048 cycles; res_data_o=128, res_chan_o=0, res_ovf_o=0.
- Contention: req_i=11 from reset → channel 0 served first, then channel 1. With req_i held at 11, the grant alternates 0,1,0.
- Saturation: CNT_W=8, osc_i[1] period 4 clocks (256 edges), req_i=10 → res_data_o=255, res_ovf_o=1.
- Backpressure: res_ready_i low 50 cycles after valid → data stable and busy_o=1 throughout; handshake → IDLE next cycle, gnt_o=00.
- Reset mid-COUNT: assert wb_rst_i at window cycle 500 → all outputs 0 immediately; the next request restarts the full sequence with a fresh count.
- SEQ_AUTO_EN with AUTO_PERIOD=4096 and req_i=00 → two conversions (channel 0 then channel 1) per period, with correct counts.
